// File: rtl/vga_tile_pkg.sv
// Shared constants and helpers for the tile-grid VGA renderer:
// 640x480@60 timing, default palette and address-width helper.
package vga_tile_pkg;

  localparam logic [9:0] H_ACTIVE     = 10'd640;
  localparam logic [9:0] H_FP         = 10'd16;
  localparam logic [9:0] H_SYNC       = 10'd96;
  localparam logic [9:0] H_BP         = 10'd48;
  localparam logic [9:0] H_TOTAL      = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam logic [9:0] H_LAST       = H_TOTAL - 10'd1;
  localparam logic [9:0] H_SYNC_START = H_ACTIVE + H_FP;
  localparam logic [9:0] H_SYNC_END   = H_SYNC_START + H_SYNC;

  localparam logic [9:0] V_ACTIVE     = 10'd480;
  localparam logic [9:0] V_FP         = 10'd10;
  localparam logic [9:0] V_SYNC       = 10'd2;
  localparam logic [9:0] V_BP         = 10'd33;
  localparam logic [9:0] V_TOTAL      = V_ACTIVE + V_FP + V_SYNC + V_BP;
  localparam logic [9:0] V_LAST       = V_TOTAL - 10'd1;
  localparam logic [9:0] V_SYNC_START = V_ACTIVE + V_FP;
  localparam logic [9:0] V_SYNC_END   = V_SYNC_START + V_SYNC;

  // Per-pixel control flags carried alongside the colour pipeline
  typedef struct packed {
    logic act;
    logic hs;
    logic vs;
    logic first;
  } sync_flags_t;

  function automatic int unsigned tile_aw(input int unsigned n);
    return (n <= 1) ? 1 : $clog2(n);
  endfunction

  // 3-bit RGB base pattern; wider colours replicate each bit
  function automatic logic [2:0] pal_default(input int unsigned idx);
    case (idx)
      0:       return 3'b111;
      1:       return 3'b100;
      2:       return 3'b010;
      3:       return 3'b001;
      4:       return 3'b110;
      5:       return 3'b011;
      6:       return 3'b101;
      default: return 3'b000;
    endcase
  endfunction

endpackage

// File: rtl/vga_timing_gen.sv
// Pixel-enable divider plus 800x525 raster counters with raw sync and
// active-area decode.
module vga_timing_gen
  import vga_tile_pkg::*;
#(
  parameter int unsigned CLK_DIV = 2
) (
  input  logic       clk,
  input  logic       rst,
  output logic       pe,
  output logic [9:0] hx,
  output logic [9:0] vy,
  output logic       hsync_raw,
  output logic       vsync_raw,
  output logic       active
);

  localparam int unsigned DW = $clog2(CLK_DIV);

  logic [DW-1:0] div_cnt;

  assign pe = (div_cnt == DW'(CLK_DIV - 1));

  always_ff @(posedge clk) begin
    if (rst)     div_cnt <= '0;
    else if (pe) div_cnt <= '0;
    else         div_cnt <= div_cnt + DW'(1);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      hx <= '0;
      vy <= '0;
    end else if (pe) begin
      if (hx == H_LAST) begin
        hx <= '0;
        vy <= (vy == V_LAST) ? '0 : vy + 10'd1;
      end else begin
        hx <= hx + 10'd1;
      end
    end
  end

  assign hsync_raw = (hx >= H_SYNC_START) && (hx < H_SYNC_END);
  assign vsync_raw = (vy >= V_SYNC_START) && (vy < V_SYNC_END);
  assign active    = (hx < H_ACTIVE) && (vy < V_ACTIVE);

endmodule

// File: rtl/vga_tile_grid.sv
// Tile-grid renderer: divider-free tile tracking, 3-stage pixel pipeline,
// runtime palette, cursor frame and grid-line overlays.
module vga_tile_grid
  import vga_tile_pkg::*;
#(
  parameter int unsigned COLS      = 4,
  parameter int unsigned ROWS      = 4,
  parameter int unsigned CW        = 3,
  parameter int unsigned IDXW      = 3,
  parameter int unsigned CLK_DIV   = 2,
  parameter int unsigned ADDR_MODE = 0,
  parameter int unsigned BORDER    = 2,
  parameter int unsigned GRID_EN   = 0
) (
  input  logic                                clk,
  input  logic                                rst,
  output logic [tile_aw(COLS*ROWS)-1:0]       tile_addr,
  input  logic [IDXW-1:0]                     tile_idx,
  input  logic [tile_aw(COLS*ROWS)-1:0]       cursor_addr,
  input  logic                                cursor_en,
  input  logic                                pal_we,
  input  logic [IDXW-1:0]                     pal_addr,
  input  logic [CW-1:0]                       pal_data,
  output logic                                hsync_n,
  output logic                                vsync_n,
  output logic [CW-1:0]                       rgb,
  output logic                                de,
  output logic                                frame_start
);

  localparam int unsigned AW       = tile_aw(COLS * ROWS);
  localparam int unsigned TW       = 32'(H_ACTIVE) / COLS;
  localparam int unsigned TH       = 32'(V_ACTIVE) / ROWS;
  localparam int unsigned SXW      = tile_aw(TW);
  localparam int unsigned SYW      = tile_aw(TH);
  localparam int unsigned CXW      = tile_aw(COLS);
  localparam int unsigned RYW      = tile_aw(ROWS);
  localparam int unsigned NPAL     = 2 ** IDXW;
  localparam int unsigned GRID_IDX = (IDXW >= 3) ? 7 : 0;
  localparam int unsigned CREP     = CW / 3;

  logic       pe;
  logic [9:0] hx, vy;
  logic       hsync_raw, vsync_raw, active;

  vga_timing_gen #(.CLK_DIV(CLK_DIV)) u_timing (
    .clk       (clk),
    .rst       (rst),
    .pe        (pe),
    .hx        (hx),
    .vy        (vy),
    .hsync_raw (hsync_raw),
    .vsync_raw (vsync_raw),
    .active    (active)
  );

  // S0: tile position tracked alongside hx/vy
  logic [SXW-1:0] sub_x;
  logic [CXW-1:0] col;
  logic [SYW-1:0] sub_y;
  logic [RYW-1:0] row;

  always_ff @(posedge clk) begin
    if (rst) begin
      sub_x <= '0;
      col   <= '0;
      sub_y <= '0;
      row   <= '0;
    end else if (pe) begin
      if (hx == H_LAST) begin
        sub_x <= '0;
        col   <= '0;
        if (vy == V_LAST) begin
          sub_y <= '0;
          row   <= '0;
        end else if (vy < V_ACTIVE) begin
          if (sub_y == SYW'(TH - 1)) begin
            sub_y <= '0;
            if (row != RYW'(ROWS - 1)) row <= row + RYW'(1);
          end else begin
            sub_y <= sub_y + SYW'(1);
          end
        end
      end else if (hx < H_ACTIVE) begin
        if (sub_x == SXW'(TW - 1)) begin
          sub_x <= '0;
          if (col != CXW'(COLS - 1)) col <= col + CXW'(1);
        end else begin
          sub_x <= sub_x + SXW'(1);
        end
      end
    end
  end

  logic [AW-1:0] addr_calc;
  logic          brd_c, grid_c;

  always_comb begin
    addr_calc = '0;
    if (ADDR_MODE == 1)
      addr_calc = AW'((COLS - 1 - 32'(col)) * ROWS + (ROWS - 1 - 32'(row)));
    else
      addr_calc = AW'(32'(row) * COLS + 32'(col));
    brd_c  = (BORDER != 0) &&
             ((32'(sub_x) < BORDER) || (32'(sub_x) >= TW - BORDER) ||
              (32'(sub_y) < BORDER) || (32'(sub_y) >= TH - BORDER));
    grid_c = (GRID_EN != 0) && ((sub_x == '0) || (sub_y == '0));
  end

  // S1: tile address and edge flags; address holds through blanking
  sync_flags_t fl_s1, fl_s2;
  logic        brd_s1, grid_s1;

  always_ff @(posedge clk) begin
    if (rst) begin
      tile_addr <= '0;
      fl_s1     <= '0;
      brd_s1    <= 1'b0;
      grid_s1   <= 1'b0;
    end else if (pe) begin
      if (active) tile_addr <= addr_calc;
      fl_s1   <= '{act: active, hs: hsync_raw, vs: vsync_raw,
                   first: (hx == '0) && (vy == '0)};
      brd_s1  <= brd_c;
      grid_s1 <= grid_c;
    end
  end

  // S2: bank data returns; cursor match uses the address it was fetched for
  logic [IDXW-1:0] idx_s2;
  logic            cur_s2, grid_s2;

  always_ff @(posedge clk) begin
    if (rst) begin
      idx_s2  <= '0;
      cur_s2  <= 1'b0;
      grid_s2 <= 1'b0;
      fl_s2   <= '0;
    end else if (pe) begin
      idx_s2  <= tile_idx;
      cur_s2  <= cursor_en && (tile_addr == cursor_addr) && brd_s1;
      grid_s2 <= grid_s1;
      fl_s2   <= fl_s1;
    end
  end

  logic [CW-1:0] pal [NPAL];

  function automatic logic [CW-1:0] pal_reset(input int unsigned i);
    logic [2:0] b;
    b = pal_default(i);
    return {{CREP{b[2]}}, {CREP{b[1]}}, {CREP{b[0]}}};
  endfunction

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int unsigned i = 0; i < NPAL; i++) pal[IDXW'(i)] <= pal_reset(i);
    end else if (pal_we) begin
      pal[pal_addr] <= pal_data;
    end
  end

  logic [CW-1:0] pal_col, rgb_d;

  always_comb begin
    pal_col = pal[idx_s2];
    rgb_d   = pal_col;
    if (!fl_s2.act)   rgb_d = '0;
    else if (cur_s2)  rgb_d = ~pal_col;
    else if (grid_s2) rgb_d = pal[IDXW'(GRID_IDX)];
  end

  // S3: aligned outputs
  always_ff @(posedge clk) begin
    if (rst) begin
      rgb         <= '0;
      de          <= 1'b0;
      hsync_n     <= 1'b1;
      vsync_n     <= 1'b1;
      frame_start <= 1'b0;
    end else begin
      frame_start <= pe && fl_s2.first && fl_s2.act;
      if (pe) begin
        rgb     <= rgb_d;
        de      <= fl_s2.act;
        hsync_n <= ~fl_s2.hs;
        vsync_n <= ~fl_s2.vs;
      end
    end
  end

endmodule
